// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux -- NCH-channel valid/ready arbiter feeding one registered output.
//
// Each cycle the output register can load (it is empty, or its beat is being
// drained downstream), one requesting channel is granted. Its data and index
// are captured into the output register on the same edge. Drain and load in
// the same cycle are lossless, so the mux sustains one beat per clock.
//
// Configuration macro:
//   ARB_MUX_RR_EN  defined   -> round-robin: search starts at a priority
//                               pointer that moves past each granted channel.
//                  undefined -> fixed priority: lowest-index valid channel
//                               wins and the pointer is a constant 0.
//
// Parameters:
//   WIDTH  data width per channel (1..64)
//   NCH    number of input channels (power of two, 2..8)
//   SELW   channel-index width, log2(NCH)
//
// Ports:
//   iClk     clock, rising edge
//   iRst_n   asynchronous active-low reset
//   iData    channel data, channel k at [k*WIDTH +: WIDTH]
//   iValid   per-channel request valid
//   oReady   per-channel accept (one-hot or zero)
//   oData    registered selected data
//   oValid   oData holds a beat
//   iReady   downstream accept
//   oSel     index of the channel whose beat is in oData
// -----------------------------------------------------------------------------
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [NCH*WIDTH-1:0] iData,
  input  logic [NCH-1:0]       iValid,
  output logic [NCH-1:0]       oReady,
  output logic [WIDTH-1:0]     oData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [SELW-1:0]      oSel
);

  logic [WIDTH-1:0] ch_data [NCH];
  logic [WIDTH-1:0] data_reg;
  logic [SELW-1:0]  sel_reg;
  logic             valid_reg;
  logic [SELW-1:0]  ptr;
  logic             load;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;

  // Unpack the flat data bus into one word per channel.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data[gi] = iData[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign load = ~valid_reg | iReady;

  // Search upward from ptr with wrap; NCH is a power of two, so the SELW-bit
  // addition wraps naturally. With ptr fixed at 0 this is plain lowest-index
  // priority.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [SELW-1:0] idx;
      idx = ptr + SELW'(i);
      if (!grant_any && iValid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Accept only when the output register can take the beat. The reset gate
  // keeps every accept low while iRst_n is asserted, independent of the clock.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign oReady[gi] = iRst_n & load & grant_any & (grant_idx == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      data_reg  <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      if (grant_any) begin
        data_reg  <= ch_data[grant_idx];
        sel_reg   <= grant_idx;
        valid_reg <= 1'b1;
      end else begin
        // Drained (or already empty) with nothing new: data and index hold.
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_RR_EN
  logic [SELW-1:0] ptr_reg;

  // Pointer moves only on an input transfer, which happens exactly when
  // load and a grant coincide; a request withdrawn without transfer leaves it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr_reg <= '0;
    end else if (load && grant_any) begin
      ptr_reg <= grant_idx + SELW'(1);
    end
  end

  assign ptr = ptr_reg;
`else
  assign ptr = '0;
`endif

  assign oData  = data_reg;
  assign oSel   = sel_reg;
  assign oValid = valid_reg;

endmodule

// File: tb/tb_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_mux -- self-checking bench for arb_mux (WIDTH=32, NCH=4).
// A scoreboard queue holds the beat expected in the output register: pushed
// when an input transfer is predicted, popped when the output drains.
// Directed sequences add fixed expected values on top of the scoreboard.
// Follows ARB_MUX_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic [NCH*WIDTH-1:0] ch_data;
  logic [NCH-1:0]   ch_valid;
  logic [NCH-1:0]   ch_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_sel;

  beat_t q[$];
  logic [1:0] model_ptr;
  int vectors;
  int miscompares;

  arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iData  (ch_data),
    .iValid (ch_valid),
    .oReady (ch_ready),
    .oData  (out_data),
    .oValid (out_valid),
    .iReady (out_ready),
    .oSel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    ch_data[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic model_reset();
    q.delete();
    model_ptr = 2'd0;
  endtask

  // One clock: compare at the falling edge, update the model, then move to
  // just after the rising edge so the caller can change inputs.
  task automatic step();
    logic       mload;
    logic       found;
    logic [1:0] gidx;
    logic [3:0] exp_rdy;
    @(negedge clk);
    mload = (q.size() == 0) || out_ready;
    found = 1'b0;
    gidx  = 2'd0;
    for (int i = 0; i < NCH; i++) begin
      logic [1:0] idx;
`ifdef ARB_MUX_RR_EN
      idx = 2'((int'(model_ptr) + i) % NCH);
`else
      idx = 2'(i);
`endif
      if (!found && ch_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    exp_rdy = (mload && found) ? (4'b0001 << gidx) : 4'b0000;
    check("oReady", 64'(ch_ready), 64'(exp_rdy));
    check("oValid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("oData", 64'(out_data), 64'(q[0].data));
      check("oSel", 64'(out_sel), 64'(q[0].sel));
      if (out_ready) void'(q.pop_front());
    end
    if (mload && found) begin
      beat_t b;
      b.sel  = gidx;
      b.data = ch_data[int'(gidx)*WIDTH +: WIDTH];
      q.push_back(b);
      model_ptr = gidx + 2'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq [5];
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst_n     = 1'b0;
    ch_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < NCH; k++) set_ch(k, 32'hA0 + 32'(k));

    // Reset held with all channels requesting.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_oValid", 64'(out_valid), 64'd0);
      check("rst_oData", 64'(out_data), 64'd0);
      check("rst_oSel", 64'(out_sel), 64'd0);
      check("rst_oReady", 64'(ch_ready), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Continuous traffic, all channels valid.
`ifdef ARB_MUX_RR_EN
    exp_seq = '{0, 1, 2, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      step();
      check("stream_sel", 64'(out_sel), 64'(exp_seq[i]));
      check("stream_data", 64'(out_data), 64'(32'hA0 + 32'(exp_seq[i])));
    end

    // Drain, then backpressure on a single channel-2 beat.
    ch_valid = 4'b0000;
    step();
    set_ch(2, 32'hDEAD_BEEF);
    set_ch(3, 32'h0000_0033);
    ch_valid  = 4'b0100;
    out_ready = 1'b0;
    step();
    ch_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
      check("bp_ready", 64'(ch_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_next_sel", 64'(out_sel), 64'd3);
    check("bp_next_data", 64'(out_data), 64'h33);

    // Wrap/skip: channel-2 transfer, then only channels 0 and 1 requesting.
    ch_valid = 4'b0100;
    step();
    ch_valid = 4'b0011;
    step();
    check("wrap_first", 64'(out_sel), 64'd0);
    step();
`ifdef ARB_MUX_RR_EN
    check("wrap_second", 64'(out_sel), 64'd1);
`else
    check("wrap_second", 64'(out_sel), 64'd0);
`endif

    // Channels 1 and 3 requesting.
    ch_valid = 4'b1010;
`ifdef ARB_MUX_RR_EN
    exp_seq = '{3, 1, 3, 1, 3};
`else
    exp_seq = '{1, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 5; i++) begin
      step();
      check("pri_sel", 64'(out_sel), 64'(exp_seq[i]));
    end

    // Random traffic against the scoreboard.
    for (int c = 0; c < 300; c++) begin
      ch_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NCH; k++) set_ch(k, $urandom);
      step();
    end

    // Asynchronous reset between edges while a beat is held.
    ch_valid  = 4'b1111;
    out_ready = 1'b0;
    step();
    step();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_oValid", 64'(out_valid), 64'd0);
    check("async_oData", 64'(out_data), 64'd0);
    check("async_oSel", 64'(out_sel), 64'd0);
    check("async_oReady", 64'(ch_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("held_oValid", 64'(out_valid), 64'd0);
    #2 rst_n = 1'b1;
    ch_valid  = 4'b1100;
    out_ready = 1'b1;
    set_ch(2, 32'h2222_0002);
    set_ch(3, 32'h3333_0003);
    #1;
    step();
    check("post_rst_sel", 64'(out_sel), 64'd2);
    check("post_rst_data", 64'(out_data), 64'h2222_0002);
    ch_valid = 4'b0000;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
